ddr_rd_burst_ctrl: RTL and testbench

DDR_RD_BURST_CTRL -- requirements
Module: ddr_rd_burst_ctrl

---
 rtl/ddr_rd_burst_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ddr_rd_burst_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_burst_ctrl.sv
// Fetches a frame from DDR as fixed-length AXI read bursts into a write-side FIFO.
// Optional burst-length checker enabled by defining DDR_RD_BURST_CHK_EN.
module ddr_rd_burst_ctrl #(
    parameter int ADDR_WIDTH       = 28,
    parameter int DATA_WIDTH       = 256,
    parameter int BURST_LEN        = 16,
    parameter int FIFO_DEPTH_WIDTH = 8,
    parameter int FRAME_BEATS      = 57600,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        frame_start,
    output logic [ADDR_WIDTH-1:0]       axi_araddr,
    output logic [7:0]                  axi_arlen,
    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    input  logic [DATA_WIDTH-1:0]       axi_rdata,
    input  logic                        axi_rvalid,
    input  logic                        axi_rlast,
    output logic                        axi_rready,
    output logic [DATA_WIDTH-1:0]       fifo_wr_data,
    output logic                        fifo_wr_en,
    input  logic                        fifo_wr_full,
    input  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        burst_err
);

    localparam int BL_W   = $clog2(FRAME_BEATS + 1);
    localparam int FREE_W = FIFO_DEPTH_WIDTH + 2;

    localparam logic [BL_W-1:0]       FRAME_BEATS_L = BL_W'(FRAME_BEATS);
    localparam logic [BL_W-1:0]       BURST_LEN_L   = BL_W'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC      = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [FREE_W-1:0]     FIFO_DEPTH_L  = FREE_W'(2 ** FIFO_DEPTH_WIDTH);
    localparam logic [FREE_W-1:0]     BURST_FREE    = FREE_W'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SPACE,
        ADDR,
        DATA
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [BL_W-1:0]         beats_left_reg;
    logic                    pending_reg;
    logic                    busy_reg;
    logic                    frame_done_reg;

    logic [FREE_W-1:0]       free_space;
    logic                    space_ok;
    logic                    beat_acc;
    logic                    burst_end;
    logic                    restart;
    logic                    last_burst;

    // Free space is computed one bit wider than the level so a full FIFO yields zero, not a wrap.
    assign free_space = FIFO_DEPTH_L - {1'b0, fifo_wr_water_level};
    assign space_ok   = (free_space >= BURST_FREE);

    assign axi_arvalid  = (state_reg == ADDR);
    assign axi_araddr   = axi_arvalid ? addr_reg : '0;
    assign axi_arlen    = 8'(BURST_LEN - 1);
    assign axi_rready   = (state_reg == DATA) && !fifo_wr_full;
    assign beat_acc     = axi_rvalid && axi_rready;
    assign fifo_wr_en   = beat_acc;
    assign fifo_wr_data = (state_reg == DATA) ? axi_rdata : '0;

    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

    // A restart request seen on the closing beat itself is honoured just like a latched one.
    assign restart    = pending_reg || frame_start;
    assign last_burst = (beats_left_reg <= BURST_LEN_L);

`ifdef DDR_RD_BURST_CHK_EN
    logic [8:0] beat_cnt_reg;
    logic       burst_err_reg;
    logic       cnt_at_end;

    assign cnt_at_end = (beat_cnt_reg == 9'(BURST_LEN - 1));
    // A misplaced or missing rlast still closes the burst so the FSM never stalls.
    assign burst_end  = beat_acc && (axi_rlast || cnt_at_end);
    assign burst_err  = burst_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg  <= '0;
            burst_err_reg <= 1'b0;
        end else begin
            if (state_reg == ADDR) begin
                beat_cnt_reg <= '0;
            end else if (beat_acc) begin
                beat_cnt_reg <= beat_cnt_reg + 9'd1;
            end
            if (beat_acc && (axi_rlast != cnt_at_end)) begin
                burst_err_reg <= 1'b1;
            end
        end
    end
`else
    assign burst_end = beat_acc && axi_rlast;
    assign burst_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr_reg       <= BASE_ADDR;
            beats_left_reg <= '0;
            pending_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    pending_reg <= 1'b0;
                    if (frame_start) begin
                        addr_reg       <= BASE_ADDR;
                        beats_left_reg <= FRAME_BEATS_L;
                        busy_reg       <= 1'b1;
                        state_reg      <= WAIT_SPACE;
                    end
                end
                WAIT_SPACE: begin
                    if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                    if (space_ok) begin
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                    if (axi_arready) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (burst_end) begin
                        frame_done_reg <= last_burst;
                        if (restart) begin
                            addr_reg       <= BASE_ADDR;
                            beats_left_reg <= FRAME_BEATS_L;
                            pending_reg    <= 1'b0;
                            state_reg      <= WAIT_SPACE;
                        end else if (last_burst) begin
                            addr_reg       <= addr_reg + ADDR_INC;
                            beats_left_reg <= '0;
                            busy_reg       <= 1'b0;
                            state_reg      <= IDLE;
                        end else begin
                            addr_reg       <= addr_reg + ADDR_INC;
                            beats_left_reg <= beats_left_reg - BURST_LEN_L;
                            state_reg      <= WAIT_SPACE;
                        end
                    end else if (frame_start) begin
                        pending_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rd_burst_ctrl.sv
// Directed bench for ddr_rd_burst_ctrl with a 32-beat frame (two 16-beat bursts of 512 bytes).
// Expected burst_err depends on whether DDR_RD_BURST_CHK_EN is defined for the build.
module tb_ddr_rd_burst_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_start;
    logic [27:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [255:0] axi_rdata;
    logic         axi_rvalid;
    logic         axi_rlast;
    logic         axi_rready;
    logic [255:0] fifo_wr_data;
    logic         fifo_wr_en;
    logic         fifo_wr_full;
    logic [8:0]   fifo_wr_water_level;
    logic         busy;
    logic         frame_done;
    logic         burst_err;

    int tests = 0;
    int fails = 0;
    int seq   = 0;

`ifdef DDR_RD_BURST_CHK_EN
    localparam logic CHK_ON = 1'b1;
`else
    localparam logic CHK_ON = 1'b0;
`endif

    ddr_rd_burst_ctrl #(
        .ADDR_WIDTH(28),
        .DATA_WIDTH(256),
        .BURST_LEN(16),
        .FIFO_DEPTH_WIDTH(8),
        .FRAME_BEATS(32),
        .BASE_ADDR(28'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata),
        .axi_rvalid(axi_rvalid),
        .axi_rlast(axi_rlast),
        .axi_rready(axi_rready),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_full(fifo_wr_full),
        .fifo_wr_water_level(fifo_wr_water_level),
        .busy(busy),
        .frame_done(frame_done),
        .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int s);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(s);
        return {4{w, ~w}};
    endfunction

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Serves one burst as the AXI slave and checks the controller's side of every cycle.
    task automatic do_burst(input logic [27:0] exp_addr, input logic [15:0] full_mask,
                            input int last_at, input int fs_at, input int ar_delay,
                            input logic exp_done, input logic exp_busy);
        int n = 0;
        while (!axi_arvalid && n < 60) begin
            tick();
            n++;
        end
        check_bit("arvalid_seen", axi_arvalid, 1'b1);
        if (!axi_arvalid) return;
        check_vec("araddr", 256'(axi_araddr), 256'(exp_addr));
        check_vec("arlen", 256'(axi_arlen), 256'(15));
        check_bit("rready_in_addr", axi_rready, 1'b0);
        for (int d = 0; d < ar_delay; d++) begin
            tick();
            check_bit("arvalid_hold", axi_arvalid, 1'b1);
            check_vec("araddr_hold", 256'(axi_araddr), 256'(exp_addr));
        end
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        check_bit("arvalid_drop", axi_arvalid, 1'b0);
        for (int k = 0; k <= last_at; k++) begin
            if (full_mask[k]) begin
                fifo_wr_full = 1'b1;
                axi_rvalid   = 1'b1;
                axi_rdata    = pat(seq);
                axi_rlast    = (k == last_at);
                #1;
                check_bit("rready_full", axi_rready, 1'b0);
                check_bit("wr_en_full", fifo_wr_en, 1'b0);
                tick();
                fifo_wr_full = 1'b0;
            end
            axi_rvalid  = 1'b1;
            axi_rdata   = pat(seq);
            axi_rlast   = (k == last_at);
            frame_start = (k == fs_at);
            #1;
            check_bit("rready", axi_rready, 1'b1);
            check_bit("wr_en", fifo_wr_en, 1'b1);
            check_vec("wr_data", fifo_wr_data, pat(seq));
            tick();
            seq++;
        end
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        axi_rdata   = '0;
        frame_start = 1'b0;
        check_bit("frame_done", frame_done, exp_done);
        check_bit("busy_after", busy, exp_busy);
        check_bit("arvalid_after", axi_arvalid, 1'b0);
        $display("[TB] burst araddr=%07h beats=%0d frame_done=%b busy=%b burst_err=%b",
                 exp_addr, last_at + 1, frame_done, busy, burst_err);
        tick();
        check_bit("frame_done_pulse", frame_done, 1'b0);
    endtask

    initial begin
        int n;
        rst_n               = 1'b0;
        frame_start         = 1'b0;
        axi_arready         = 1'b0;
        axi_rdata           = '0;
        axi_rvalid          = 1'b0;
        axi_rlast           = 1'b0;
        fifo_wr_full        = 1'b0;
        fifo_wr_water_level = '0;

        // Reset state
        tick();
        tick();
        check_bit("rst_arvalid", axi_arvalid, 1'b0);
        check_bit("rst_rready", axi_rready, 1'b0);
        check_bit("rst_wr_en", fifo_wr_en, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", frame_done, 1'b0);
        check_bit("rst_err", burst_err, 1'b0);
        check_vec("rst_araddr", 256'(axi_araddr), 256'(0));
        check_vec("rst_arlen", 256'(axi_arlen), 256'(15));
        rst_n = 1'b1;
        tick();

        // Plain two-burst frame
        pulse_start();
        check_bit("busy_start", busy, 1'b1);
        do_burst(28'h000, 16'h0000, 15, -1, 0, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("idle_no_arvalid", axi_arvalid, 1'b0);
        end

        // Water-level threshold, arready back-pressure and FIFO-full stalls
        fifo_wr_water_level = 9'd241;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            tick();
            check_bit("wl241_no_arvalid", axi_arvalid, 1'b0);
        end
        fifo_wr_water_level = 9'd240;
        tick();
        check_bit("wl240_arvalid", axi_arvalid, 1'b1);
        fifo_wr_water_level = 9'd0;
        do_burst(28'h000, 16'b0000_0010_0001_1000, 15, -1, 2, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);

        // frame_start mid-burst restarts at the base address without frame_done
        pulse_start();
        do_burst(28'h000, 16'h0000, 15, 5, 0, 1'b0, 1'b1);
        do_burst(28'h000, 16'h0000, 15, -1, 0, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);

        // frame_start on the final rlast: frame_done and a fresh frame
        pulse_start();
        do_burst(28'h000, 16'h0000, 15, -1, 0, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, 15, 0, 1'b1, 1'b1);
        do_burst(28'h000, 16'h0000, 15, -1, 0, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);

        // Early rlast on the tenth beat ends the burst; error flag only with the checker
        check_bit("err_before_short", burst_err, 1'b0);
        pulse_start();
        do_burst(28'h000, 16'h0000, 9, -1, 0, 1'b0, 1'b1);
        check_bit("err_after_short", burst_err, CHK_ON);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);
        check_bit("err_sticky", burst_err, CHK_ON);

        // Asynchronous reset in the middle of a burst
        pulse_start();
        n = 0;
        while (!axi_arvalid && n < 60) begin
            tick();
            n++;
        end
        check_bit("mid_arvalid_seen", axi_arvalid, 1'b1);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        axi_rvalid  = 1'b1;
        axi_rdata   = pat(seq);
        #1;
        check_bit("mid_rready", axi_rready, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_rready", axi_rready, 1'b0);
        check_bit("arst_wr_en", fifo_wr_en, 1'b0);
        check_bit("arst_busy", busy, 1'b0);
        check_bit("arst_err", burst_err, 1'b0);
        axi_rvalid = 1'b0;
        axi_rdata  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_bit("post_rst_arvalid", axi_arvalid, 1'b0);
        pulse_start();
        do_burst(28'h000, 16'h0000, 15, -1, 0, 1'b0, 1'b1);
        do_burst(28'h200, 16'h0000, 15, -1, 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
